// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters that stall issue on RAW
// hazards or counter saturation, plus a starvation-guarded arbiter for the RF write port.
`timescale 1ns/1ps
module regfile_scoreboard #(
    parameter int CW         = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nrst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic [4:0]  issue_rd,
    input  logic        issue_wen,
    output logic        issue_stall,
    input  logic        wb_valid,
    input  logic [4:0]  wb_sel,
    input  logic [31:0] wb_dat,
    output logic        wb_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_sel,
    input  logic [31:0] lu_dat,
    output logic        lu_ready,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic        sb_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam int            SW      = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        PIPE_PRI = 1'b0,
        LU_PRI   = 1'b1
    } arb_t;

    arb_t          state;
    arb_t          state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    logic [CW-1:0] cnt_q  [1:31];
    logic [CW-1:0] cnt_rd [0:31];
    logic [31:1]   inc_vec;
    logic [31:1]   dec_vec;

    logic          grant;
    logic [4:0]    win_sel;
    logic [31:0]   win_dat;
    logic          issue_sat;
    logic          issue_acc;
    logic          err_hit;

    // Register 0 is hardwired to zero and never tracked, so it always reads as idle.
    always_comb begin
        cnt_rd[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_rd[r] = cnt_q[r];
        end
    end

    // Stall looks only at registered counts: a retire this cycle frees the reader next cycle,
    // which is exactly when the RF write becomes visible.
    assign issue_sat   = issue_wen & (issue_rd != 5'd0) & (cnt_rd[issue_rd] == CNT_MAX);
    assign issue_stall = issue_valid & ((cnt_rd[issue_rs] != '0) |
                                        (cnt_rd[issue_rt] != '0) |
                                        issue_sat);
    assign issue_acc   = issue_valid & ~issue_stall & issue_wen & (issue_rd != 5'd0);

    // NOTE: every output of this block gets a default before any branch; a path that left one
    // unassigned would infer a latch.
    always_comb begin
        wb_ready   = 1'b0;
        lu_ready   = 1'b0;
        state_nxt  = PIPE_PRI;
        starve_nxt = starve_cnt;
        if (state == LU_PRI && lu_valid) begin
            lu_ready   = 1'b1;
            starve_nxt = '0;
        end else if (wb_valid) begin
            wb_ready = 1'b1;
            if (lu_valid) begin
                if (starve_cnt < STARVE_LIM) begin
                    starve_nxt = starve_cnt + SW'(1);
                end
                if (starve_cnt + SW'(1) >= STARVE_LIM) begin
                    state_nxt = LU_PRI;
                end
            end
        end else if (lu_valid) begin
            lu_ready   = 1'b1;
            starve_nxt = '0;
        end
    end

    assign grant   = wb_ready | lu_ready;
    assign win_sel = lu_ready ? lu_sel : (wb_ready ? wb_sel : 5'd0);
    assign win_dat = lu_ready ? lu_dat : (wb_ready ? wb_dat : 32'd0);

    assign rf_WEN  = grant & (win_sel != 5'd0);
    assign rf_wsel = win_sel;
    assign rf_wdat = win_dat;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < 32; r++) begin
            inc_vec[r] = issue_acc & (issue_rd == 5'(r));
            dec_vec[r] = grant & (win_sel == 5'(r));
        end
    end

    assign err_hit = grant & (win_sel != 5'd0) & (cnt_rd[win_sel] == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state      <= PIPE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // NOTE: the counter array is reset explicitly: it is a bank of flops holding hazard state,
    // not a RAM, and a stale nonzero count would stall its readers forever.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt_q[r] <= cnt_q[r] + CW'(1);
                end else if (dec_vec[r] && !inc_vec[r] && cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - CW'(1);
                end
            end
            if (err_hit) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a per-cycle compare against a pending-count model
// plus hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_regfile_scoreboard;

    localparam int CW         = 2;
    localparam int STARVE_MAX = 4;
    localparam int CNT_MAX    = (1 << CW) - 1;

    logic        CLK = 1'b0;
    logic        nrst;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        issue_wen;
    logic        issue_stall;
    logic        wb_valid;
    logic [4:0]  wb_sel;
    logic [31:0] wb_dat;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_sel;
    logic [31:0] lu_dat;
    logic        lu_ready;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        sb_err;

    regfile_scoreboard #(.CW(CW), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .nrst(nrst),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_stall(issue_stall),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_dat(wb_dat), .wb_ready(wb_ready),
        .lu_valid(lu_valid), .lu_sel(lu_sel), .lu_dat(lu_dat), .lu_ready(lu_ready),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .sb_err(sb_err)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: outstanding writes per register, sticky error, and LU denial bookkeeping.
    int          pend [32];
    bit          m_err;
    int          denials;
    bit          forced;
    logic        e_stall, e_wb, e_lu, e_wen;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic predict();
        e_stall = issue_valid && (pend[issue_rs] > 0 || pend[issue_rt] > 0 ||
                  (issue_wen && issue_rd != 5'd0 && pend[issue_rd] == CNT_MAX));
        e_wb = 1'b0;
        e_lu = 1'b0;
        if (forced && lu_valid) e_lu = 1'b1;
        else if (wb_valid)      e_wb = 1'b1;
        else if (lu_valid)      e_lu = 1'b1;
        e_wsel = e_lu ? lu_sel : (e_wb ? wb_sel : 5'd0);
        e_wdat = e_lu ? lu_dat : (e_wb ? wb_dat : 32'd0);
        e_wen  = (e_wb || e_lu) && e_wsel != 5'd0;
    endtask

    always @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            foreach (pend[i]) pend[i] = 0;
            m_err   = 1'b0;
            denials = 0;
            forced  = 1'b0;
        end else begin
            bit retire;
            predict();
            retire = 1'b0;
            if (e_wen) begin
                if (pend[e_wsel] == 0) m_err = 1'b1;
                else retire = 1'b1;
            end
            if (issue_valid && !e_stall && issue_wen && issue_rd != 5'd0) pend[issue_rd]++;
            if (retire) pend[e_wsel]--;
            if (e_lu) begin
                denials = 0;
                forced  = 1'b0;
            end else if (e_wb && lu_valid) begin
                denials++;
                forced = (denials >= STARVE_MAX);
            end else begin
                forced = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (nrst === 1'b1) begin
            predict();
            check("cmp issue_stall", issue_stall, e_stall);
            check("cmp wb_ready",    wb_ready,    e_wb);
            check("cmp lu_ready",    lu_ready,    e_lu);
            check("cmp rf_WEN",      rf_WEN,      e_wen);
            check("cmp rf_wsel",     rf_wsel,     e_wsel);
            check("cmp rf_wdat",     rf_wdat,     e_wdat);
            check("cmp sb_err",      sb_err,      m_err);
        end
    end

    task automatic clr();
        issue_valid = 1'b0; issue_rs = 5'd0; issue_rt = 5'd0; issue_rd = 5'd0; issue_wen = 1'b0;
        wb_valid = 1'b0; wb_sel = 5'd0; wb_dat = 32'd0;
        lu_valid = 1'b0; lu_sel = 5'd0; lu_dat = 32'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        clr();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic wen);
        issue_valid = 1'b1; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wen = wen;
    endtask

    task automatic wb(input logic [4:0] sel, input logic [31:0] dat);
        wb_valid = 1'b1; wb_sel = sel; wb_dat = dat;
    endtask

    task automatic lu(input logic [4:0] sel, input logic [31:0] dat);
        lu_valid = 1'b1; lu_sel = sel; lu_dat = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        clr();
        issue(5'd3, 5'd4, 5'd5, 1'b1);
        wb(5'd6, 32'hA5A5_0006);
        #3;
        check("reset stall",   issue_stall, 1'b0);
        check("reset wb_rdy",  wb_ready,    1'b1);
        check("reset lu_rdy",  lu_ready,    1'b0);
        check("reset rf_wsel", rf_wsel,     5'd6);
        check("reset sb_err",  sb_err,      1'b0);
        tick();
        settle();
        check("reset idle WEN",  rf_WEN,  1'b0);
        check("reset idle wsel", rf_wsel, 5'd0);
        check("reset idle wdat", rf_wdat, 32'd0);
        tick();
        nrst = 1'b1;

        // T1: RAW hazard on r5 released by a pipeline retire
        tick(); issue(5'd1, 5'd2, 5'd5, 1'b1); settle();
        check("T1 first issue", issue_stall, 1'b0);
        tick(); issue(5'd5, 5'd0, 5'd6, 1'b1); settle();
        check("T1 raw stall", issue_stall, 1'b1);
        tick(); issue(5'd5, 5'd0, 5'd6, 1'b1); settle();
        check("T1 raw hold", issue_stall, 1'b1);
        tick(); issue(5'd5, 5'd0, 5'd6, 1'b1); wb(5'd5, 32'hDEAD_BEEF); settle();
        check("T1 stall on grant", issue_stall, 1'b1);
        check("T1 wb_ready",       wb_ready,    1'b1);
        check("T1 rf_WEN",         rf_WEN,      1'b1);
        check("T1 rf_wsel",        rf_wsel,     5'd5);
        check("T1 rf_wdat",        rf_wdat,     32'hDEAD_BEEF);
        tick(); issue(5'd5, 5'd0, 5'd6, 1'b1); settle();
        check("T1 released", issue_stall, 1'b0);
        tick(); wb(5'd6, 32'h0000_0006); settle();
        check("T1 retire r6 wsel", rf_wsel, 5'd6);

        // T2: counter saturation on r7
        for (int i = 0; i < 3; i++) begin
            tick(); issue(5'd0, 5'd0, 5'd7, 1'b1); settle();
            check("T2 fill issue", issue_stall, 1'b0);
        end
        tick(); issue(5'd0, 5'd0, 5'd7, 1'b1); settle();
        check("T2 saturated", issue_stall, 1'b1);
        tick(); issue(5'd0, 5'd0, 5'd7, 1'b1); wb(5'd7, 32'h7); settle();
        check("T2 no bypass", issue_stall, 1'b1);
        tick(); issue(5'd0, 5'd0, 5'd7, 1'b1); settle();
        check("T2 accepted after retire", issue_stall, 1'b0);
        tick(); issue(5'd0, 5'd0, 5'd7, 1'b1); settle();
        check("T2 saturated again", issue_stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); wb(5'd7, 32'h70 + i); settle();
            check("T2 drain WEN", rf_WEN, 1'b1);
        end
        tick(); issue(5'd0, 5'd7, 5'd0, 1'b0); settle();
        check("T2 drained", issue_stall, 1'b0);

        // T3: starvation guard with wb and lu both held
        tick(); issue(5'd0, 5'd0, 5'd11, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick(); wb(5'd0, 32'h100 + c); lu(5'd11, 32'hCAFE_0011); settle();
            if (c < 5) begin
                check("T3 wb wins",     wb_ready, 1'b1);
                check("T3 lu denied",   lu_ready, 1'b0);
                check("T3 sel0 no WEN", rf_WEN,   1'b0);
            end else begin
                check("T3 forced wb",   wb_ready, 1'b0);
                check("T3 forced lu",   lu_ready, 1'b1);
                check("T3 forced WEN",  rf_WEN,   1'b1);
                check("T3 forced wsel", rf_wsel,  5'd11);
                check("T3 forced wdat", rf_wdat,  32'hCAFE_0011);
            end
        end
        tick(); wb(5'd0, 32'h1); lu(5'd0, 32'h2); settle();
        check("T3 back to pipe pri", wb_ready, 1'b1);
        tick(); lu(5'd0, 32'h3); settle();
        check("T3 lu alone", lu_ready, 1'b1);

        // T4: same-cycle issue and retire on r9
        tick(); issue(5'd0, 5'd0, 5'd9, 1'b1); settle();
        check("T4 first issue", issue_stall, 1'b0);
        tick(); issue(5'd0, 5'd0, 5'd9, 1'b1); wb(5'd9, 32'h9); settle();
        check("T4 issue accepted", issue_stall, 1'b0);
        check("T4 retire granted", wb_ready,    1'b1);
        tick(); issue(5'd9, 5'd0, 5'd0, 1'b0); settle();
        check("T4 count still one", issue_stall, 1'b1);
        tick(); wb(5'd9, 32'h99);
        tick(); issue(5'd9, 5'd0, 5'd0, 1'b0); settle();
        check("T4 cleared", issue_stall, 1'b0);
        check("T4 no error", sb_err, 1'b0);

        // T5: retire of an idle register and of r0
        tick(); wb(5'd12, 32'h12); settle();
        check("T5 idle retire WEN",  rf_WEN, 1'b1);
        check("T5 err not yet",      sb_err, 1'b0);
        tick(); settle();
        check("T5 err set", sb_err, 1'b1);
        tick(); wb(5'd0, 32'h55); settle();
        check("T5 r0 wb_ready", wb_ready, 1'b1);
        check("T5 r0 no WEN",   rf_WEN,   1'b0);
        check("T5 r0 wsel",     rf_wsel,  5'd0);
        tick(); issue(5'd12, 5'd0, 5'd0, 1'b0); settle();
        check("T5 r12 stays idle", issue_stall, 1'b0);
        check("T5 err sticky",     sb_err,      1'b1);

        // T6: reset while r3 has two pending and the arbiter is in LU_PRI
        tick(); issue(5'd0, 5'd0, 5'd3, 1'b1);
        tick(); issue(5'd0, 5'd0, 5'd3, 1'b1);
        for (int c = 0; c < STARVE_MAX; c++) begin
            tick(); wb(5'd0, 32'h0); lu(5'd0, 32'h0);
        end
        tick(); issue(5'd3, 5'd0, 5'd0, 1'b0); settle();
        check("T6 r3 busy before reset", issue_stall, 1'b1);
        nrst = 1'b0;
        wb(5'd0, 32'h0); lu(5'd0, 32'h0);
        #1;
        check("T6 err cleared", sb_err,      1'b0);
        check("T6 r3 idle",     issue_stall, 1'b0);
        check("T6 pipe pri",    wb_ready,    1'b1);
        check("T6 lu waits",    lu_ready,    1'b0);
        tick();
        nrst = 1'b1;
        issue(5'd3, 5'd0, 5'd0, 1'b0); wb(5'd0, 32'h0); lu(5'd0, 32'h0); settle();
        check("T6 after reset stall", issue_stall, 1'b0);
        check("T6 after reset wb",    wb_ready,    1'b1);
        tick(); settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
